// File: rtl/bram_sdp_param.sv
// Simple-dual-port block RAM with selectable read-during-write behaviour,
// optional output register and a post-reset clear engine that presets every word.
module bram_sdp_param #(
    parameter int                DATA_W   = 2,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter int                RDW_MODE = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q_out,
    output logic              q_valid,
    output logic              init_busy
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] clr_cnt_reg, clr_cnt_next;

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == LAST_C) begin
                state_next = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign init_busy = (state_reg == ST_CLEAR);

    logic ready;
    logic wr_in_range, rd_in_range;
    logic user_wr, user_rd;

    assign ready       = (state_reg == ST_READY);
    assign wr_in_range = ({1'b0, waddr} < DEPTH_C);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_C);
    assign user_wr     = ready & enable & write_en;
    assign user_rd     = ready & enable & read_en;

    // The clear engine borrows the single write port; user writes only exist in READY.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (!rst) begin
            if (state_reg == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_reg[ADDR_W-1:0];
                mem_wdata = INIT_VAL;
            end else begin
                mem_we = user_wr & wr_in_range;
            end
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Plain registered read keeps the array mappable to a BRAM primitive;
    // bypass and zeroing are applied by flags registered alongside it.
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (user_rd && rd_in_range) begin
            rd_data_reg <= mem[raddr];
        end
    end

    logic              rd_valid_reg;
    logic              rd_zero_reg;
    logic              rd_byp_reg;
    logic [DATA_W-1:0] rd_byp_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
            rd_byp_reg   <= 1'b0;
        end else if (user_rd) begin
            rd_valid_reg    <= 1'b1;
            rd_zero_reg     <= ~rd_in_range;
            rd_byp_reg      <= (RDW_MODE != 0) && user_wr && (waddr == raddr);
            rd_byp_data_reg <= wdata;
        end else begin
            rd_valid_reg <= 1'b0;
        end
    end

    logic [DATA_W-1:0] rd_result;

    always_comb begin
        if (rd_zero_reg) begin
            rd_result = '0;
        end else if (rd_byp_reg) begin
            rd_result = rd_byp_data_reg;
        end else begin
            rd_result = rd_data_reg;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q_out_reg;
            logic              q_valid_reg;

            // Not gated by enable so reads already in flight still complete.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_out_reg   <= '0;
                    q_valid_reg <= 1'b0;
                end else begin
                    q_valid_reg <= rd_valid_reg;
                    if (rd_valid_reg) begin
                        q_out_reg <= rd_result;
                    end
                end
            end

            assign q_out   = q_out_reg;
            assign q_valid = q_valid_reg;
        end else begin : g_no_out_reg
            assign q_out   = rd_result;
            assign q_valid = rd_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_param.sv
// Drives three RAM variants (read-old/latency 1, write-first/latency 2,
// non-power-of-two depth with nonzero preset) from one stimulus stream.
module tb_bram_sdp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, write_en, read_en;
    logic [3:0] waddr, raddr;
    logic [1:0] wdata;

    logic [1:0] q_out     [3];
    logic       q_valid   [3];
    logic       init_busy [3];

    bram_sdp_param #(.DATA_W(2), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(2'b00)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .write_en(write_en), .waddr(waddr), .wdata(wdata),
        .read_en(read_en), .raddr(raddr), .q_out(q_out[0]), .q_valid(q_valid[0]), .init_busy(init_busy[0]));

    bram_sdp_param #(.DATA_W(2), .ADDR_W(4), .DEPTH(16), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(2'b00)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .write_en(write_en), .waddr(waddr), .wdata(wdata),
        .read_en(read_en), .raddr(raddr), .q_out(q_out[1]), .q_valid(q_valid[1]), .init_busy(init_busy[1]));

    bram_sdp_param #(.DATA_W(2), .ADDR_W(4), .DEPTH(12), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(2'b01)) u_c (
        .clk(clk), .rst(rst), .enable(enable), .write_en(write_en), .waddr(waddr), .wdata(wdata),
        .read_en(read_en), .raddr(raddr), .q_out(q_out[2]), .q_valid(q_valid[2]), .init_busy(init_busy[2]));

    // Reference model: word array, remaining clear cycles and a delay slot for latency-2 reads.
    int         dep_m  [3] = '{16, 16, 12};
    int         rdw_m  [3] = '{0, 1, 0};
    int         lat_m  [3] = '{1, 2, 1};
    logic [1:0] init_m [3] = '{2'b00, 2'b00, 2'b01};
    logic [1:0] mem_m  [3][16];
    int         busy_m [3];
    int         clr_m  [3];
    logic [1:0] exp_q  [3];
    logic       exp_v  [3];
    logic       stg_v  [3];
    logic [1:0] stg_d  [3];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int inst, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, inst, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [1:0] rv;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy_m[i] = dep_m[i];
                clr_m[i]  = 0;
                stg_v[i]  = 1'b0;
                exp_v[i]  = 1'b0;
                exp_q[i]  = 2'b00;
            end else begin
                exp_v[i] = 1'b0;
                if (stg_v[i]) begin
                    exp_v[i] = 1'b1;
                    exp_q[i] = stg_d[i];
                    stg_v[i] = 1'b0;
                end
                if (busy_m[i] > 0) begin
                    mem_m[i][clr_m[i]] = init_m[i];
                    clr_m[i]++;
                    busy_m[i]--;
                end else begin
                    if (enable && read_en) begin
                        if (int'(raddr) >= dep_m[i])
                            rv = 2'b00;
                        else if (rdw_m[i] == 1 && write_en && waddr == raddr)
                            rv = wdata;
                        else
                            rv = mem_m[i][raddr];
                        if (lat_m[i] == 1) begin
                            exp_v[i] = 1'b1;
                            exp_q[i] = rv;
                        end else begin
                            stg_v[i] = 1'b1;
                            stg_d[i] = rv;
                        end
                    end
                    if (enable && write_en && int'(waddr) < dep_m[i])
                        mem_m[i][waddr] = wdata;
                end
            end
        end
    endtask

    int cyc_n = 0;

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < 3; i++) begin
            chk("q_valid", i, {1'b0, q_valid[i]}, {1'b0, exp_v[i]});
            chk("q_out", i, q_out[i], exp_q[i]);
            chk("init_busy", i, {1'b0, init_busy[i]}, {1'b0, (busy_m[i] > 0)});
        end
        $display("cyc=%0d rst=%0b en=%0b we=%0b wa=%0d wd=%0d re=%0b ra=%0d | q=%0d/%0d/%0d v=%0b%0b%0b busy=%0b%0b%0b",
                 cyc_n, rst, enable, write_en, waddr, wdata, read_en, raddr,
                 q_out[0], q_out[1], q_out[2], q_valid[0], q_valid[1], q_valid[2],
                 init_busy[0], init_busy[1], init_busy[2]);
    endtask

    task automatic drive(input logic r, input logic en, input logic we, input logic [3:0] wa,
                         input logic [1:0] wd, input logic re, input logic [3:0] ra);
        rst = r; enable = en; write_en = we; waddr = wa; wdata = wd; read_en = re; raddr = ra;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; write_en = 1'b0; read_en = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;

        // reset state, then full clear window and readback of the preset value
        drive(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'd0);
        idle(16);
        for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'(a));
        idle(2);

        // write then read back
        drive(1'b0, 1'b1, 1'b1, 4'd3, 2'b10, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd3);
        idle(2);

        // same-address read during write
        drive(1'b0, 1'b1, 1'b1, 4'd5, 2'b01, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b1, 4'd5, 2'b11, 1'b1, 4'd5);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5);
        idle(2);

        // enable low blocks both ports; a read already in flight still lands
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd3);
        drive(1'b0, 1'b0, 1'b1, 4'd7, 2'b11, 1'b1, 4'd7);
        drive(1'b0, 1'b0, 1'b1, 4'd7, 2'b11, 1'b1, 4'd7);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd7);
        idle(2);

        // out-of-range address on the 12-deep variant
        drive(1'b0, 1'b1, 1'b1, 4'd13, 2'b11, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd13);
        for (int a = 0; a < 12; a++) drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'(a));
        idle(2);

        // reset in the middle of a clear with writes attempted throughout
        drive(1'b0, 1'b1, 1'b1, 4'd9, 2'b10, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 1'b1, 4'd9, 2'b11, 1'b1, 4'd9);
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b1, 4'(k), 2'b11, 1'b1, 4'(k));
        drive(1'b1, 1'b1, 1'b1, 4'd2, 2'b10, 1'b1, 4'd2);
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b1, 4'(k), 2'b10, 1'b1, 4'(k));
        for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'(a));
        idle(2);

        // random traffic with frequent address collisions and rare resets
        for (int k = 0; k < 600; k++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
